// File: rtl/alu_opb_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_opb_seq (with local combinational B unit alu_opB)
// Brief    : Iterative sequencer that drives a single-operand B unit once per
//            clock, feeding each result back as the next operand. Collects
//            sticky carry/overflow and returns the final value on a
//            valid/ready response channel.
// Options  : ALU_OPB_SEQ_EARLY_EXIT_EN - stop iterating on the first carry or
//            overflow instead of always running the full count.
// Revision : 1.0 - initial release
// ============================================================================

// Combinational single-operand unit. res[OP_WIDTH] carries the carry-out.
module alu_opB #(
    parameter int OP_WIDTH  = 8,
    parameter int CMD_WIDTH = 2
) (
    input  logic                 enable,
    input  logic                 mode,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [OP_WIDTH-1:0]  opb,
    output logic [OP_WIDTH:0]    res,
    output logic                 oflow
);
    // Arithmetic commands (mode=1)
    localparam logic [CMD_WIDTH-1:0] c_INC_B  = CMD_WIDTH'(0);
    // Logic/shift commands (mode=0); anything else shifts left
    localparam logic [CMD_WIDTH-1:0] c_NOT_B  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] c_SHR1_B = CMD_WIDTH'(1);

    localparam logic [OP_WIDTH:0]   c_ONE_X = {{OP_WIDTH{1'b0}}, 1'b1};
    localparam logic [OP_WIDTH-1:0] c_ONE   = {{(OP_WIDTH-1){1'b0}}, 1'b1};

    // Select the operation; idle unit drives zeros
    always_comb begin
        res   = '0;
        oflow = 1'b0;
        if (enable) begin
            if (mode) begin
                if (cmd == c_INC_B) begin
                    res = {1'b0, opb} + c_ONE_X;
                end else begin
                    // Decrement wraps; underflow reported on oflow, not carry
                    res   = {1'b0, opb - c_ONE};
                    oflow = (opb == '0);
                end
            end else begin
                case (cmd)
                    c_NOT_B:  res = {1'b0, ~opb};
                    c_SHR1_B: res = {1'b0, opb >> 1};
                    default:  res = {1'b0, opb << 1};
                endcase
            end
        end
    end
endmodule

module alu_opb_seq #(
    parameter int OP_WIDTH  = 8,
    parameter int CMD_WIDTH = 2,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_mode,
    input  logic [CMD_WIDTH-1:0] req_cmd,
    input  logic [OP_WIDTH-1:0]  req_opb,
    input  logic [CNT_WIDTH-1:0] req_count,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OP_WIDTH-1:0]  rsp_res,
    output logic                 rsp_cout,
    output logic                 rsp_oflow,
    output logic [CNT_WIDTH-1:0] rsp_iters,
    output logic                 busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_mode;
    logic [CMD_WIDTH-1:0] r_cmd;
    logic [CNT_WIDTH-1:0] r_count;
    logic [OP_WIDTH-1:0]  r_acc;
    logic                 r_cout;
    logic                 r_oflow;
    logic [CNT_WIDTH-1:0] r_iters;

    logic                 w_b_enable;
    logic [OP_WIDTH:0]    w_b_res;
    logic                 w_b_cout;
    logic                 w_b_oflow;
    logic [CNT_WIDTH-1:0] w_iters_next;
    logic                 w_last;
    logic                 w_done;

    assign w_b_enable   = (r_state == S_RUN);
    assign w_b_cout     = w_b_res[OP_WIDTH];
    assign w_iters_next = r_iters + c_CNT_ONE;

`ifdef ALU_OPB_SEQ_EARLY_EXIT_EN
    assign w_last = (w_iters_next == r_count) || w_b_cout || w_b_oflow;
`else
    assign w_last = (w_iters_next == r_count);
`endif

    alu_opB #(
        .OP_WIDTH  (OP_WIDTH),
        .CMD_WIDTH (CMD_WIDTH)
    ) u_opb (
        .enable (w_b_enable),
        .mode   (r_mode),
        .cmd    (r_cmd),
        .opb    (r_acc),
        .res    (w_b_res),
        .oflow  (w_b_oflow)
    );

    // Sequencer state, operand accumulator, sticky flags and iteration count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_cmd   <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_cout  <= 1'b0;
            r_oflow <= 1'b0;
            r_iters <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mode  <= req_mode;
                        r_cmd   <= req_cmd;
                        r_count <= req_count;
                        r_acc   <= req_opb;
                        r_cout  <= 1'b0;
                        r_oflow <= 1'b0;
                        r_iters <= '0;
                        r_state <= (req_count == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_b_res[OP_WIDTH-1:0];
                    r_cout  <= r_cout | w_b_cout;
                    r_oflow <= r_oflow | w_b_oflow;
                    r_iters <= w_iters_next;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake and response outputs; all forced low while reset is asserted
    assign w_done    = (r_state == S_DONE) && !rst;
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE) && !rst;
    assign rsp_valid = w_done;
    assign rsp_res   = w_done ? r_acc   : '0;
    assign rsp_cout  = w_done ? r_cout  : 1'b0;
    assign rsp_oflow = w_done ? r_oflow : 1'b0;
    assign rsp_iters = w_done ? r_iters : '0;
endmodule
`default_nettype wire

// File: tb/tb_alu_opb_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_opb_seq
// Brief    : Self-checking bench for alu_opb_seq (OP_WIDTH=8, CNT_WIDTH=4).
//            Honours ALU_OPB_SEQ_EARLY_EXIT_EN for the expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_opb_seq;
    localparam logic [1:0] c_INC  = 2'd0;
    localparam logic [1:0] c_DEC  = 2'd1;
    localparam logic [1:0] c_NOT  = 2'd0;
    localparam logic [1:0] c_SHR1 = 2'd1;
    localparam logic [1:0] c_SHL1 = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_mode;
    logic [1:0] req_cmd;
    logic [7:0] req_opb;
    logic [3:0] req_count;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_res;
    logic       rsp_cout;
    logic       rsp_oflow;
    logic [3:0] rsp_iters;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       mode;
        logic [1:0] cmd;
        logic [7:0] opb;
        logic [3:0] count;
        logic [7:0] res;
        logic       cout;
        logic       oflow;
        logic [3:0] iters;
    } vec_t;

    vec_t vecs[10];
    vec_t sb_q[$];

    alu_opb_seq #(.OP_WIDTH(8), .CMD_WIDTH(2), .CNT_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_cmd   (req_cmd),
        .req_opb   (req_opb),
        .req_count (req_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_cout  (rsp_cout),
        .rsp_oflow (rsp_oflow),
        .rsp_iters (rsp_iters),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait for req_ready, present a request for one accepting edge, record expectation
    task automatic send(input vec_t v, input bit expect_rsp);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_mode  = v.mode;
        req_cmd   = v.cmd;
        req_opb   = v.opb;
        req_count = v.count;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_opb   = 8'hA5;
        req_count = 4'hF;
        if (expect_rsp) sb_q.push_back(v);
    endtask

    // Wait for the response, compare against the scoreboard head, then pop it
    task automatic collect();
        int   lat;
        vec_t e;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else if (rsp_valid) begin
            e = sb_q.pop_front();
            check("rsp_res",   rsp_res,   e.res);
            check("rsp_cout",  rsp_cout,  e.cout);
            check("rsp_oflow", rsp_oflow, e.oflow);
            check("rsp_iters", rsp_iters, e.iters);
            check("latency",   lat,       e.iters);
            check("busy_done", busy,      1);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check("pop_rsp_valid", rsp_valid, 0);
            check("pop_req_ready", req_ready, 1);
            check("pop_rsp_res",   rsp_res,   0);
        end
    endtask

    initial begin
        vec_t v1;
        vec_t v2;
        vec_t e;
        int   seen;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        req_cmd   = 2'd0;
        req_opb   = 8'h00;
        req_count = 4'h0;
        rsp_ready = 1'b0;

        // mode, cmd, opb, count, res, cout, oflow, iters
`ifdef ALU_OPB_SEQ_EARLY_EXIT_EN
        vecs[0] = '{1'b1, c_INC,  8'hFE, 4'd3,  8'h00, 1'b1, 1'b0, 4'd2};
        vecs[7] = '{1'b1, c_DEC,  8'h00, 4'd3,  8'hFF, 1'b0, 1'b1, 4'd1};
`else
        vecs[0] = '{1'b1, c_INC,  8'hFE, 4'd3,  8'h01, 1'b1, 1'b0, 4'd3};
        vecs[7] = '{1'b1, c_DEC,  8'h00, 4'd3,  8'hFD, 1'b0, 1'b1, 4'd3};
`endif
        vecs[1] = '{1'b1, c_DEC,  8'h01, 4'd2,  8'hFF, 1'b0, 1'b1, 4'd2};
        vecs[2] = '{1'b0, c_SHL1, 8'h81, 4'd3,  8'h08, 1'b0, 1'b0, 4'd3};
        vecs[3] = '{1'b0, c_NOT,  8'h5A, 4'd2,  8'h5A, 1'b0, 1'b0, 4'd2};
        vecs[4] = '{1'b0, c_NOT,  8'h3C, 4'd0,  8'h3C, 1'b0, 1'b0, 4'd0};
        vecs[5] = '{1'b0, c_SHR1, 8'h80, 4'd4,  8'h08, 1'b0, 1'b0, 4'd4};
        vecs[6] = '{1'b1, c_INC,  8'h10, 4'd15, 8'h1F, 1'b0, 1'b0, 4'd15};
        vecs[8] = '{1'b0, c_NOT,  8'h00, 4'd1,  8'hFF, 1'b0, 1'b0, 4'd1};
        vecs[9] = '{1'b1, c_INC,  8'hFF, 4'd1,  8'h00, 1'b1, 1'b0, 4'd1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_rsp_res",   rsp_res,   0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", req_ready, 1);
        check("idle_busy",      busy,      0);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            send(vecs[i], 1'b1);
            if (vecs[i].count == 4'd0) begin
                check("cnt0_b_disabled", dut.w_b_enable, 0);
            end else begin
                check("run_busy", busy, 1);
                check("run_req_ready", req_ready, 0);
            end
            collect();
        end

        // Backpressure: hold the response while another request waits
        v1 = '{1'b1, c_INC, 8'h00, 4'd1, 8'h01, 1'b0, 1'b0, 4'd1};
        v2 = '{1'b0, c_NOT, 8'h0F, 4'd1, 8'hF0, 1'b0, 1'b0, 4'd1};
        send(v1, 1'b1);
        seen = 0;
        while (!rsp_valid && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        req_mode  = v2.mode;
        req_cmd   = v2.cmd;
        req_opb   = v2.opb;
        req_count = v2.count;
        req_valid = 1'b1;
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_res",   rsp_res,   e.res);
            check("bp_rsp_iters", rsp_iters, e.iters);
            check("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_after_pop_ready", req_ready, 1);
        check("bp_after_pop_busy",  busy,      0);
        @(posedge clk); #1;
        check("bp_accept_busy",  busy,      1);
        check("bp_accept_ready", req_ready, 0);
        req_valid = 1'b0;
        sb_q.push_back(v2);
        collect();

        // Reset pulse during RUN abandons the operation
        v1 = '{1'b1, c_INC, 8'h00, 4'd10, 8'h0A, 1'b0, 1'b0, 4'd10};
        send(v1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_rst_req_ready", req_ready, 0);
        check("abort_rst_busy",      busy,      0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_busy",      busy,      0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_res",   rsp_res,   0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("abort_no_response", seen, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
